apb_rr_arbiter: RTL and testbench

Round-robin arbiter and APB transfer sequencer that shares one APB completer port between NUM_REQ internal requesters. It accepts per-requester read/write commands over valid/ready and runs the APB SETUP/ACCESS protocol. It returns read data and error status to the owning requester, and aborts stalled transfers after a programmable timeout. It sits between the block-level command sources and the peripheral APB bus. It replaces the single-source cmd_i interface of the existing APB master.

---
 rtl/apb_rr_arbiter.sv | 104 ++++++++++
 tb/tb_apb_rr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin arbiter sharing one APB completer between NUM_REQ requesters, with stall timeout
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ-1:0]    req_write_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*DW-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]         rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic [AW-1:0]         paddr_o,
  output logic                  pwrite_o,
  output logic [DW-1:0]         pwdata_o,
  input  logic                  pready_i,
  input  logic [DW-1:0]         prdata_i,
  input  logic                  pslverr_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_next;
  logic [PW-1:0] ptr, owner, win, hi_w, lo_w;
  logic [CW-1:0] cnt;
  logic hi, lo, found, abort, done, grant, sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  assign psel_o = state != IDLE;
  assign penable_o = state == ACCESS;
  assign abort = (TIMEOUT > 0) && state == ACCESS && !pready_i && cnt == CW'(TMAX);
  assign done = state == ACCESS && (pready_i || abort);
  assign grant = reset_n && (state == IDLE || done) && found;
  assign req_ready_o = grant ? (ONE << win) : '0;
  // winner is the lowest valid index at or above ptr, else the lowest valid index below it
  always_comb begin
    hi = 1'b0;
    lo = 1'b0;
    hi_w = '0;
    lo_w = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k] && k >= int'(ptr)) begin hi = 1'b1; hi_w = PW'(k); end
      if (req_valid_i[k] && k < int'(ptr)) begin lo = 1'b1; lo_w = PW'(k); end
    end
    found = hi | lo;
    win = hi ? hi_w : lo_w;
  end
  // payload of the current winner
  always_comb begin
    sel_write = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == PW'(k)) begin
        sel_write = req_write_i[k];
        sel_addr = req_addr_i[k*AW +: AW];
        sel_wdata = req_wdata_i[k*DW +: DW];
      end
    end
  end
  // APB phase sequencing: SETUP lasts one cycle, ACCESS until completion or abort
  always_comb begin
    state_next = grant ? SETUP : state == SETUP ? ACCESS : done ? IDLE : state;
  end
  // state, arbitration pointer, captured command, wait counter and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      paddr_o <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        owner <= win;
        paddr_o <= sel_addr;
        pwrite_o <= sel_write;
        pwdata_o <= sel_wdata;
        cnt <= '0;
      end else if (state == ACCESS && !pready_i) begin
        cnt <= cnt + 1'b1;
      end
      rsp_valid_o <= done ? (ONE << owner) : '0;
      rsp_err_o <= done && (abort || pslverr_i);
      rsp_rdata_o <= (done && !abort && !pwrite_o) ? prdata_i : '0;
    end
  end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: directed vectors, corner sequences and randomized model comparison for apb_rr_arbiter
module tb_apb_rr_arbiter;
  localparam int N = 4;
  localparam int T = 16;
  typedef struct {
    logic rn; logic [3:0] v; logic [3:0] wr; logic rdy; logic er; logic [31:0] rd;
    logic [3:0] xr; logic xs; logic xe; logic [31:0] xa; logic xw; logic [31:0] xd;
    logic [3:0] xv; logic [31:0] xq; logic xerr;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n, pready, pslverr;
  logic [3:0] v, wr, gnt;
  logic [31:0] a [4];
  logic [31:0] w [4];
  logic [127:0] addr_p, wdata_p;
  logic [31:0] prdata, rsp_rdata, paddr, pwdata;
  logic [3:0] req_ready, rsp_valid;
  logic rsp_err, psel, penable, pwrite;
  int checks = 0;
  int errors = 0;
  vec_t tv [23];
  bit m_busy, m_pen, m_abort, m_done, found, m_pwrite, m_err;
  int m_setup, m_ptr, m_owner, cyc, acc, stall;
  logic [1:0] kk, wk;
  logic [31:0] m_paddr, m_pwdata, m_rdata;
  logic [3:0] m_rv;
  logic [3:0] rr_rdy [8];
  logic [3:0] rr_rv [8];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      addr_p[k*32 +: 32] = a[k];
      wdata_p[k*32 +: 32] = w[k];
    end
  end

  apb_rr_arbiter #(.NUM_REQ(N), .AW(32), .DW(32), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(v), .req_write_i(wr),
    .req_addr_i(addr_p), .req_wdata_i(wdata_p), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic rn, logic [3:0] vv, logic [3:0] ww, logic rdy, logic er, logic [31:0] rd,
                              logic [3:0] xr, logic xs, logic xe, logic [31:0] xa, logic xw, logic [31:0] xd,
                              logic [3:0] xv, logic [31:0] xq, logic xerr);
    vec_t t;
    t.rn = rn; t.v = vv; t.wr = ww; t.rdy = rdy; t.er = er; t.rd = rd;
    t.xr = xr; t.xs = xs; t.xe = xe; t.xa = xa; t.xw = xw; t.xd = xd;
    t.xv = xv; t.xq = xq; t.xerr = xerr;
    return t;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    v = '0;
    wr = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    prdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    tv[0]  = mk(0, 4'hF, 0, 0, 0, 0,     4'h0, 0, 0, 32'h00, 0, 32'h00, 4'h0, 0, 0);
    tv[1]  = mk(1, 4'h1, 4'h1, 1, 0, 0,  4'h1, 0, 0, 32'h00, 0, 32'h00, 4'h0, 0, 0);
    tv[2]  = mk(1, 4'h0, 0, 1, 0, 0,     4'h0, 1, 0, 32'h10, 1, 32'hA5, 4'h0, 0, 0);
    tv[3]  = mk(1, 4'h0, 0, 1, 0, 0,     4'h0, 1, 1, 32'h10, 1, 32'hA5, 4'h0, 0, 0);
    tv[4]  = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 0, 0, 32'h10, 1, 32'hA5, 4'h1, 0, 0);
    tv[5]  = mk(1, 4'h4, 0, 0, 0, 0,     4'h4, 0, 0, 32'h10, 1, 32'hA5, 4'h0, 0, 0);
    tv[6]  = mk(1, 4'h0, 0, 1, 0, 0,     4'h0, 1, 0, 32'h20, 0, 32'hC7, 4'h0, 0, 0);
    tv[7]  = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 1, 1, 32'h20, 0, 32'hC7, 4'h0, 0, 0);
    tv[8]  = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 1, 1, 32'h20, 0, 32'hC7, 4'h0, 0, 0);
    tv[9]  = mk(1, 4'h0, 0, 1, 0, 5,     4'h0, 1, 1, 32'h20, 0, 32'hC7, 4'h0, 0, 0);
    tv[10] = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 0, 0, 32'h20, 0, 32'hC7, 4'h4, 5, 0);
    tv[11] = mk(1, 4'h2, 0, 1, 1, 0,     4'h2, 0, 0, 32'h20, 0, 32'hC7, 4'h0, 0, 0);
    tv[12] = mk(1, 4'h0, 0, 1, 1, 0,     4'h0, 1, 0, 32'h18, 0, 32'hB6, 4'h0, 0, 0);
    tv[13] = mk(1, 4'h0, 0, 1, 1, 32'h77, 4'h0, 1, 1, 32'h18, 0, 32'hB6, 4'h0, 0, 0);
    tv[14] = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 0, 0, 32'h18, 0, 32'hB6, 4'h2, 32'h77, 1);
    tv[15] = mk(1, 4'h2, 4'h2, 0, 0, 0,  4'h2, 0, 0, 32'h18, 0, 32'hB6, 4'h0, 0, 0);
    tv[16] = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 1, 0, 32'h18, 1, 32'hB6, 4'h0, 0, 0);
    tv[17] = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 1, 1, 32'h18, 1, 32'hB6, 4'h0, 0, 0);
    tv[18] = mk(0, 4'hA, 4'h2, 1, 0, 0,  4'h0, 1, 1, 32'h18, 1, 32'hB6, 4'h0, 0, 0);
    tv[19] = mk(1, 4'hA, 4'h2, 1, 0, 0,  4'h2, 0, 0, 32'h00, 0, 32'h00, 4'h0, 0, 0);
    tv[20] = mk(1, 4'h8, 0, 1, 0, 0,     4'h0, 1, 0, 32'h18, 1, 32'hB6, 4'h0, 0, 0);
    tv[21] = mk(1, 4'h8, 0, 1, 0, 0,     4'h8, 1, 1, 32'h18, 1, 32'hB6, 4'h0, 0, 0);
    tv[22] = mk(1, 4'h0, 0, 0, 0, 0,     4'h0, 1, 0, 32'h28, 0, 32'hD8, 4'h2, 0, 0);
    rr_rdy = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    rr_rv  = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8};
    a = '{32'h10, 32'h18, 32'h20, 32'h28};
    w = '{32'hA5, 32'hB6, 32'hC7, 32'hD8};
    @(negedge clk);
    do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 23; i++) begin
      reset_n = tv[i].rn; v = tv[i].v; wr = tv[i].wr;
      pready = tv[i].rdy; pslverr = tv[i].er; prdata = tv[i].rd;
      #1;
      chk($sformatf("t%0d ready", i), 32'(req_ready), 32'(tv[i].xr));
      chk($sformatf("t%0d psel", i), 32'(psel), 32'(tv[i].xs));
      chk($sformatf("t%0d penable", i), 32'(penable), 32'(tv[i].xe));
      chk($sformatf("t%0d paddr", i), paddr, tv[i].xa);
      chk($sformatf("t%0d pwrite", i), 32'(pwrite), 32'(tv[i].xw));
      chk($sformatf("t%0d pwdata", i), pwdata, tv[i].xd);
      chk($sformatf("t%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].xv));
      if (tv[i].xv != 0) begin
        chk($sformatf("t%0d rsp_rdata", i), rsp_rdata, tv[i].xq);
        chk($sformatf("t%0d rsp_err", i), 32'(rsp_err), 32'(tv[i].xerr));
      end
      @(negedge clk);
    end
    do_reset();
    v = 4'b1011;
    pready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr c%0d ready", c), 32'(req_ready), 32'(rr_rdy[c]));
      chk($sformatf("rr c%0d psel", c), 32'(psel), 32'(c >= 1));
      chk($sformatf("rr c%0d penable", c), 32'(penable), 32'(c >= 2 && c % 2 == 0));
      chk($sformatf("rr c%0d rsp_valid", c), 32'(rsp_valid), 32'(rr_rv[c]));
      @(negedge clk);
    end
    do_reset();
    for (int c = 0; c < 36; c++) begin
      v[0] = c == 0;
      v[2] = c >= 5 && c <= 17;
      pready = c == 34;
      prdata = (c == 34) ? 32'h99 : 32'hDEAD;
      #1;
      chk($sformatf("to c%0d ready", c), 32'(req_ready), (c == 0) ? 32'h1 : (c == 17) ? 32'h4 : 32'h0);
      chk($sformatf("to c%0d penable", c), 32'(penable), 32'((c >= 2 && c <= 17) || (c >= 19 && c <= 34)));
      chk($sformatf("to c%0d rsp_valid", c), 32'(rsp_valid), (c == 18) ? 32'h1 : (c == 35) ? 32'h4 : 32'h0);
      if (c == 18) begin
        chk("to abort err", 32'(rsp_err), 32'h1);
        chk("to abort rdata", rsp_rdata, 32'h0);
        chk("to next setup psel", 32'(psel), 32'h1);
        chk("to next setup paddr", paddr, 32'h20);
      end
      if (c == 35) begin
        chk("to ready wins err", 32'(rsp_err), 32'h0);
        chk("to ready wins rdata", rsp_rdata, 32'h99);
      end
      @(negedge clk);
    end
    gnt = '0;
    stall = 0;
    cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      v &= ~gnt;
      reset_n = (c < 2) ? 1'b0 : ($urandom_range(0, 299) != 0);
      for (int k = 0; k < N; k++) begin
        if (v[k]) begin
          if ($urandom_range(0, 19) == 0) v[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v[k] = 1'b1; wr[k] = 1'($urandom); a[k] = $urandom; w[k] = $urandom;
        end
      end
      if (stall > 0) begin
        pready = 1'b0;
        stall--;
      end else begin
        if ($urandom_range(0, 99) == 0) stall = $urandom_range(10, 24);
        pready = $urandom_range(0, 2) != 0;
      end
      prdata = $urandom;
      pslverr = $urandom_range(0, 7) == 0;
      #1;
      m_pen = m_busy && cyc > m_setup;
      acc = cyc - m_setup - 1;
      m_abort = m_pen && !pready && acc == T - 1;
      m_done = m_pen && (pready || m_abort);
      found = 1'b0;
      wk = '0;
      if (reset_n && (!m_busy || m_done)) begin
        for (int i = 0; i < N; i++) begin
          kk = 2'((m_ptr + i) % N);
          if (!found && v[kk]) begin found = 1'b1; wk = kk; end
        end
      end
      gnt = found ? (4'h1 << wk) : 4'h0;
      if (c >= 1) begin
        chk("rnd ready", 32'(req_ready), 32'(gnt));
        chk("rnd psel", 32'(psel), 32'(m_busy));
        chk("rnd penable", 32'(penable), 32'(m_pen));
        chk("rnd paddr", paddr, m_paddr);
        chk("rnd pwrite", 32'(pwrite), 32'(m_pwrite));
        chk("rnd pwdata", pwdata, m_pwdata);
        chk("rnd rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv != 0) begin
          chk("rnd rsp_rdata", rsp_rdata, m_rdata);
          chk("rnd rsp_err", 32'(rsp_err), 32'(m_err));
        end
      end
      if (!reset_n) begin
        m_busy = 0; m_ptr = 0; m_owner = 0; m_setup = 0;
        m_paddr = '0; m_pwrite = 0; m_pwdata = '0; m_rv = '0; m_rdata = '0; m_err = 0;
      end else begin
        m_rv = m_done ? (4'h1 << m_owner) : 4'h0;
        m_err = m_done && (m_abort || pslverr);
        m_rdata = (m_done && !m_abort && !m_pwrite) ? prdata : 32'h0;
        if (found) begin
          m_busy = 1; m_setup = cyc + 1; m_owner = int'(wk); m_ptr = (int'(wk) + 1) % N;
          m_paddr = a[wk]; m_pwrite = wr[wk]; m_pwdata = w[wk];
        end else if (m_done) begin
          m_busy = 0;
        end
      end
      cyc++;
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
